logic_op_arbiter: RTL and testbench
===================================

LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0, req1  input  1 each  requester 0/1 request; held high until acknowledged.
REQ-005 op0, op1  input  3 each  operation select per requester.
REQ-006 A0, B0, A1, B1  input  WIDTH each  operands per requester.
REQ-007 ack0, ack1  output  1 each  one-cycle pulse: request accepted, operands captured.
REQ-008 out  output  WIDTH  registered result.
REQ-009 out_valid  output  1  out, out_tag and out_zero are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_tag  output  1  index of the requester that owns the result.
REQ-012 out_zero  output  1  high when out is all zeros.

Function
REQ-013 Op encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A, 111 pass A; all bitwise across WIDTH.
REQ-014 FSM states: IDLE and BUSY only.
REQ-015 IDLE with no request: stays IDLE, ack0/ack1 low, out_valid low.
REQ-016 IDLE with one request: that requester is granted.
REQ-017 IDLE with both requests: the requester not granted last time is granted (round-robin).
REQ-018 On grant in cycle N: the matching ack pulses high in cycle N. At the edge ending cycle N, the result of the selected op is registered into out, out_tag is set, and the FSM moves to BUSY. out_valid is high from cycle N+1.
REQ-019 At most one ack is high in any cycle. No ack is issued while in BUSY.
REQ-020 BUSY: out, out_tag, out_zero and out_valid hold stable until out_ready is sampled high.
REQ-021 BUSY with out_ready high: moves to IDLE next cycle and out_valid drops. A pending request is granted in the following IDLE cycle, so peak throughput is one op per 2 cycles.
REQ-022 Requests arriving or withdrawn during BUSY have no effect on the held result.
REQ-023 out_zero is computed from the registered out, not from the next value.
REQ-024 Operands and op are sampled only in the grant cycle. Later changes do not affect the result.

Reset
REQ-025 Asserting rst at any time, including mid-BUSY: FSM goes to IDLE, out=0, out_valid=0, out_tag=0, ack0=ack1=0, and the in-flight result is discarded.
REQ-026 On reset, last-grant is set to requester 1, so requester 0 wins the first contention.
REQ-027 After rst deasserts, the first grant can occur in the first clock cycle.

Structure
REQ-028 Op encodings, the WIDTH default and the FSM state encodings live in a shared package, logic_ops_pkg.
REQ-029 The combinational bitwise unit is a separate sub-module, logic_unit. It takes op, A and B and produces the result, and is instantiated once and shared by both requesters.
REQ-030 The arbiter adds no other combinational path from inputs to out.

Verification
REQ-031 Single op: req0=1, op0=011, A0=16'hFFFF, B0=16'h00FF -> ack0 in cycle N; out=16'hFF00, out_tag=0, out_valid=1 from cycle N+1.
REQ-032 Contention: req0=req1=1 right after reset -> ack0 first. After out_ready, ack1 follows, with req0 still high. Grants alternate 0,1,0,1 over 4 ops.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles with req1 pending -> out stable, no ack1. Then out_ready=1 -> IDLE, and ack1 two cycles after the out_ready edge.
REQ-034 All ops: A=16'hA5A5, B=16'h0F0F on each of the 8 codes -> outputs match bitwise expectations. Op 110 gives 16'h5A5A.
REQ-035 Zero flag: op=000, A=16'hF0F0, B=16'h0F0F -> out=0, out_zero=1.
REQ-036 Mid-op reset: assert rst in BUSY -> out_valid=0 and out=0 immediately. After release, req0 and req1 contend -> ack0 first.

Source files
------------

// File: rtl/logic_ops_pkg.sv
// Shared definitions for the logic-op arbiter: op codes, default width and
// FSM state encodings.
package logic_ops_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/logic_unit.sv
// Purely combinational bitwise unit shared by both requesters.
module logic_unit
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = a;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_NOTA: res = ~a;
      OP_PASS: res = a;
      default: res = a;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Two-requester round-robin arbiter in front of one shared logic unit; the
// granted op's result is registered and held until the consumer takes it.
module logic_op_arbiter
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_tag,
  output logic             out_zero
);

  state_e           state, state_nxt;
  logic             last_gnt;
  logic             gnt_vld, gnt_sel;
  op_e              sel_op;
  logic [WIDTH-1:0] sel_a, sel_b, res;

  always_comb begin
    state_nxt = state;
    gnt_vld   = 1'b0;
    gnt_sel   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          gnt_vld   = 1'b1;
          // On contention the requester that lost last time wins.
          gnt_sel   = (req0 && req1) ? ~last_gnt : req1;
          state_nxt = BUSY;
        end
      end
      BUSY: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ack0   = gnt_vld & ~gnt_sel;
  assign ack1   = gnt_vld &  gnt_sel;
  assign sel_op = op_e'(gnt_sel ? op1 : op0);
  assign sel_a  = gnt_sel ? A1 : A0;
  assign sel_b  = gnt_sel ? B1 : B0;

  logic_unit #(.WIDTH(WIDTH)) u_lu (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .res(res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      out      <= '0;
      out_tag  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt_vld) begin
        out      <= res;
        out_tag  <= gnt_sel;
        last_gnt <= gnt_sel;
      end
    end
  end

  assign out_valid = (state == BUSY);
  assign out_zero  = ~|out;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Scoreboard bench: stimulus pushes expected results on each ack, a monitor
// compares every cycle the DUT holds a valid result.
module tb_logic_op_arbiter;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] out;
    logic         tag;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [2:0]   op0 = '0, op1 = '0;
  logic [W-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic         ack0, ack1;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_tag;
  logic         out_zero;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  logic_op_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1), .ack0(ack0), .ack1(ack1),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_zero(out_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for an ack at the negedge; checks it belongs to 'who'.
  task automatic wait_ack(input logic who, input string name);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        got = 1;
        check({name, "_onehot"}, {31'd0, ack0 & ack1}, 32'd0);
        check({name, "_who"}, {31'd0, ack1}, {31'd0, who});
      end
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL %s: no ack within 20 cycles, expected ack%0d", name, who);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] o, input logic t);
    mk.out  = o;
    mk.tag  = t;
    mk.zero = (o == '0);
  endfunction

  task automatic single(input logic who, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] res, input string name);
    if (who) begin req1 = 1; op1 = op; A1 = a; B1 = b; end
    else     begin req0 = 1; op0 = op; A0 = a; B0 = b; end
    wait_ack(who, name);
    sb.push_back(mk(res, who));
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    // Scramble operands after grant; held result must not change.
    A0 = ~a; A1 = ~a; op0 = ~op; op1 = ~op;
  endtask

  // Monitor: compare whenever out_valid, pop once the result was accepted.
  initial begin
    bit pend_pop = 0;
    forever begin
      @(negedge clk);
      if (pend_pop && sb.size() > 0) void'(sb.pop_front());
      pend_pop = 0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_result: got out=%h tag=%0d with empty scoreboard", out, out_tag);
        end else begin
          check("mon_out",  {16'd0, out},       {16'd0, sb[0].out});
          check("mon_tag",  {31'd0, out_tag},   {31'd0, sb[0].tag});
          check("mon_zero", {31'd0, out_zero},  {31'd0, sb[0].zero});
          if (out_ready) pend_pop = 1;
        end
      end
    end
  end

  logic [W-1:0] allops[8] = '{16'h0505, 16'hAFAF, 16'hAAAA, 16'hFAFA,
                              16'h5050, 16'h5555, 16'h5A5A, 16'hA5A5};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out",   {16'd0, out}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_tag",   {31'd0, out_tag}, 32'd0);
    check("rst_acks",  {30'd0, ack1, ack0}, 32'd0);

    // Single NAND op granted in the first cycle after reset release
    @(posedge clk); #1;
    rst = 0;
    req0 = 1; op0 = 3'b011; A0 = 16'hFFFF; B0 = 16'h00FF;
    @(negedge clk);
    check("first_cycle_ack0", {31'd0, ack0}, 32'd1);
    check("first_cycle_valid", {31'd0, out_valid}, 32'd0);
    sb.push_back(mk(16'hFF00, 1'b0));
    @(posedge clk); #1;
    req0 = 0;
    @(negedge clk);
    check("nand_valid_n1", {31'd0, out_valid}, 32'd1);
    repeat (2) @(negedge clk);

    // Contention: fresh reset, both held high, grants must alternate 0,1,0,1
    rst = 1; #1; rst = 0;
    @(posedge clk); #1;
    req0 = 1; op0 = 3'b010; A0 = 16'h1234; B0 = 16'h00FF;
    req1 = 1; op1 = 3'b001; A1 = 16'hF000; B1 = 16'h000F;
    for (int k = 0; k < 4; k++) begin
      wait_ack(k[0], "contend");
      sb.push_back(k[0] ? mk(16'hF00F, 1'b1) : mk(16'h12CB, 1'b0));
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clk);

    // Backpressure: result held 5 cycles, pending req1 gets no ack
    @(posedge clk); #1;
    out_ready = 0;
    single(1'b0, 3'b000, 16'hFFFF, 16'h1234, 16'h1234, "bp_first");
    req1 = 1; op1 = 3'b111; A1 = 16'hBEEF; B1 = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_no_ack1", {30'd0, ack1, ack0}, 32'd0);
      check("bp_valid_held", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    check("bp_still_busy_ack", {31'd0, ack1}, 32'd0);
    wait_ack(1'b1, "bp_ack1");
    sb.push_back(mk(16'hBEEF, 1'b1));
    @(posedge clk); #1;
    req1 = 0;
    repeat (2) @(negedge clk);

    // All eight op codes, alternating requesters
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] c;
      c = 3'(i);
      single(c[0], c, 16'hA5A5, 16'h0F0F, allops[i], "allops");
    end
    repeat (2) @(negedge clk);

    // Zero flag
    @(posedge clk); #1;
    single(1'b0, 3'b000, 16'hF0F0, 16'h0F0F, 16'h0000, "zero");
    repeat (2) @(negedge clk);

    // Mid-op reset, then contention must favor requester 0
    @(posedge clk); #1;
    out_ready = 0;
    single(1'b1, 3'b111, 16'h1357, 16'h0000, 16'h1357, "midrst_op");
    @(negedge clk); #2;
    rst = 1;
    sb.delete();
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out",   {16'd0, out}, 32'd0);
    check("midrst_tag",   {31'd0, out_tag}, 32'd0);
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    req0 = 1; op0 = 3'b001; A0 = 16'h00F0; B0 = 16'h0F00;
    req1 = 1; op1 = 3'b110; A1 = 16'hFFFF; B1 = 16'h0000;
    wait_ack(1'b0, "midrst_first");
    sb.push_back(mk(16'h0FF0, 1'b0));
    wait_ack(1'b1, "midrst_second");
    sb.push_back(mk(16'h0000, 1'b1));
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    repeat (4) @(negedge clk);

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
